// File: rtl/pipe_add_if.sv
// pipe_add_if: operand/result handshake bundle for pipe_add.
// master = the side that supplies operands and consumes results,
// slave  = the adder itself.
interface pipe_add_if #(
    parameter int WIDTH = 32
);
    // operand side
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;

    // result side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/pipe_add.sv
// pipe_add: pipelined WIDTH-bit adder/subtractor.
// The word is cut into STAGES chunks of CW bits; stage k adds chunk k using
// the carry registered by stage k-1. Each stage register holds one word whose
// low chunks are finished result bits and whose high chunks are still-pending
// operand bits, so operand skew and result de-skew fall out of the same
// register. The whole pipe advances together whenever the output can move.
// Optional: define PIPE_ADD_FLAGS_EN to build the ovf/zero flag logic;
// without it both flags are tied to 0.
module pipe_add #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic      clk,
    input  logic      reset,
    pipe_add_if.slave bus
);
    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipe_add: WIDTH must be a positive integer multiple of STAGES");
    end

    // stage registers
    logic             valid_q [STAGES];
    logic             carry_q [STAGES];
    logic [WIDTH-1:0] x_q     [STAGES];  // result chunks <= k, pending a chunks > k
    logic [WIDTH-1:0] y_q     [STAGES];  // pending b chunks (already inverted for sub)

    // stage inputs and combinational results
    logic             valid_in  [STAGES];
    logic             carry_in  [STAGES];
    logic [WIDTH-1:0] x_in      [STAGES];
    logic [WIDTH-1:0] y_in      [STAGES];
    logic [WIDTH-1:0] x_nxt     [STAGES];
    logic             carry_nxt [STAGES];
    logic [CW:0]      part;

    logic advance;

    assign advance      = !valid_q[LAST] || bus.out_ready;
    assign bus.in_ready = advance;

    // Feed the new beat into stage 0 and each stage's registers into the next.
    always_comb begin
        // NOTE: every signal this block drives is assigned on every path, so no latch is inferred.
        valid_in[0] = bus.in_valid;
        x_in[0]     = bus.a;
        y_in[0]     = bus.sub ? ~bus.b : bus.b;
        carry_in[0] = bus.sub | bus.cin;
        for (int k = 1; k < STAGES; k++) begin
            valid_in[k] = valid_q[k-1];
            x_in[k]     = x_q[k-1];
            y_in[k]     = y_q[k-1];
            carry_in[k] = carry_q[k-1];
        end
    end

    // Each stage adds its own chunk and splices the result back into the word.
    always_comb begin
        part = '0;
        for (int k = 0; k < STAGES; k++) begin
            part = {1'b0, x_in[k][k*CW +: CW]}
                 + {1'b0, y_in[k][k*CW +: CW]}
                 + {{CW{1'b0}}, carry_in[k]};
            x_nxt[k]              = x_in[k];
            x_nxt[k][k*CW +: CW]  = part[CW-1:0];
            carry_nxt[k]          = part[CW];
        end
    end

    // Pipeline registers: all stages shift together when the output can move.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: datapath registers are cleared as well as the valid bits because sum/cout must read 0 out of reset.
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
                x_q[k]     <= '0;
                y_q[k]     <= '0;
            end
        end else if (advance) begin
            // NOTE: non-blocking assignments so each stage captures its neighbour's pre-edge value.
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= valid_in[k];
                carry_q[k] <= carry_nxt[k];
                x_q[k]     <= x_nxt[k];
                y_q[k]     <= y_in[k];
            end
        end
    end

    assign bus.out_valid = valid_q[LAST];
    assign bus.sum       = x_q[LAST];
    assign bus.cout      = carry_q[LAST];

`ifdef PIPE_ADD_FLAGS_EN
    logic ovf_nxt;
    logic zero_nxt;
    logic ovf_q;
    logic zero_q;

    // Carry into the MSB is recovered as a_msb ^ b_msb ^ sum_msb of the last chunk.
    always_comb begin
        ovf_nxt  = (x_in[LAST][WIDTH-1] ^ y_in[LAST][WIDTH-1] ^ x_nxt[LAST][WIDTH-1])
                 ^ carry_nxt[LAST];
        zero_nxt = (x_nxt[LAST] == '0);
    end

    // Flags ride alongside the last stage register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            ovf_q  <= ovf_nxt;
            zero_q <= zero_nxt;
        end
    end

    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
`else
    assign bus.ovf  = 1'b0;
    assign bus.zero = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_add.sv
// tb_pipe_add: self-checking bench for pipe_add (WIDTH=32, STAGES=4).
// Directed vectors from a table, hand-written stall and reset sequences, and
// a randomized run checked by a scoreboard fed from an arithmetic model.
// Expected ovf/zero follow PIPE_ADD_FLAGS_EN (forced to 0 when undefined).
module tb_pipe_add;
    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    pipe_add_if #(.WIDTH(WIDTH)) bus ();

    pipe_add #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } result_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    localparam int NVEC = 11;
    vec_t    vecs [NVEC];
    result_t exp_q [$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Flags only exist when the option is built in.
    function automatic logic flag_exp(input logic f);
`ifdef PIPE_ADD_FLAGS_EN
        return f;
`else
        return 1'b0 & f;
`endif
    endfunction

    // Reference: plain wide integer arithmetic on unsigned and signed views.
    function automatic result_t model(input logic [31:0] a, input logic [31:0] b,
                                      input logic sub, input logic cin);
        result_t r;
        longint  ua, ub, full, sres;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        if (sub) begin
            full   = ua - ub;
            r.cout = (ua >= ub);
            sres   = longint'($signed(a)) - longint'($signed(b));
        end else begin
            full   = ua + ub + longint'(cin);
            r.cout = (full >= 64'sh1_0000_0000);
            sres   = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        end
        r.sum  = full[31:0];
        r.ovf  = flag_exp((sres > 64'sd2147483647) || (sres < -64'sd2147483648));
        r.zero = flag_exp(r.sum == 32'd0);
        return r;
    endfunction

    function automatic vec_t mkvec(input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, input logic cin,
                                   input logic [31:0] sum, input logic cout,
                                   input logic ovf, input logic zero);
        vec_t v;
        v.a = a; v.b = b; v.sub = sub; v.cin = cin;
        v.sum = sum; v.cout = cout; v.ovf = ovf; v.zero = zero;
        return v;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push at acceptance, compare every cycle a result is shown.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", 64'(bus.out_valid), 64'd0);
            end else if (bus.out_valid) begin
                check("scoreboard_result", 64'({bus.sum, bus.cout, bus.ovf, bus.zero}), 64'(exp_q[0]));
                if (bus.out_ready) void'(exp_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.a, bus.b, bus.sub, bus.cin));
        end
    end

    // One beat with out_ready high: checks acceptance, latency and result.
    task automatic run_beat(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic sub, input logic cin, input logic [31:0] e_sum,
                            input logic e_cout, input logic e_ovf, input logic e_zero);
        logic acc;
        logic seen;
        int   lat;
        bus.a = a; bus.b = b; bus.sub = sub; bus.cin = cin;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
        end
        check({name, "_accept"}, 64'(acc), 64'd1);
        // Inputs change right after acceptance; the beat must not notice.
        bus.in_valid = 1'b0;
        bus.a = ~a; bus.b = ~b; bus.sub = ~sub; bus.cin = ~cin;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat <= 20) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
            else begin
                tick();
                lat++;
            end
        end
        check({name, "_latency"}, 64'(lat), 64'(STAGES));
        check({name, "_sum"},  64'(bus.sum),  64'(e_sum));
        check({name, "_cout"}, 64'(bus.cout), 64'(e_cout));
        check({name, "_ovf"},  64'(bus.ovf),  64'(flag_exp(e_ovf)));
        check({name, "_zero"}, 64'(bus.zero), 64'(flag_exp(e_zero)));
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, got, cyc, n_sent;
        logic acc_now;

        //                a             b             sub   cin   sum           cout  ovf   zero
        vecs[0]  = mkvec(32'd5,        32'd7,        1'b0, 1'b0, 32'd12,       1'b0, 1'b0, 1'b0);
        vecs[1]  = mkvec(32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, 32'd0,        1'b1, 1'b0, 1'b1);
        vecs[2]  = mkvec(32'h7FFFFFFF, 32'd1,        1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        vecs[3]  = mkvec(32'd3,        32'd5,        1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mkvec(32'd5,        32'd3,        1'b1, 1'b0, 32'd2,        1'b1, 1'b0, 1'b0);
        vecs[5]  = mkvec(32'hFFFFFFFF, 32'd0,        1'b0, 1'b1, 32'd0,        1'b1, 1'b0, 1'b1);
        vecs[6]  = mkvec(32'd10,       32'd10,       1'b1, 1'b1, 32'd0,        1'b1, 1'b0, 1'b1);
        vecs[7]  = mkvec(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'd0,        1'b1, 1'b1, 1'b1);
        vecs[8]  = mkvec(32'h80000000, 32'd1,        1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
        vecs[9]  = mkvec(32'h0000FFFF, 32'd1,        1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);
        vecs[10] = mkvec(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 1'b0);

        // Reset with a beat offered the whole time; it must be ignored.
        bus.in_valid  = 1'b1;
        bus.a         = 32'hDEAD_BEEF;
        bus.b         = 32'h1234_5678;
        bus.sub       = 1'b0;
        bus.cin       = 1'b1;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_sum",       64'(bus.sum),       64'd0);
        check("rst_cout",      64'(bus.cout),      64'd0);
        check("rst_ovf",       64'(bus.ovf),       64'd0);
        check("rst_zero",      64'(bus.zero),      64'd0);
        tick();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        tick();

        // Directed vectors.
        for (int i = 0; i < NVEC; i++)
            run_beat($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin,
                     vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].zero);

        // Ten back-to-back beats a=b=i, output stalled in cycles 6..8.
        idx = 0; got = 0; cyc = 0;
        while ((idx < 10 || got < 10) && cyc < 100) begin
            bus.in_valid  = (idx < 10);
            bus.a         = 32'(idx);
            bus.b         = 32'(idx);
            bus.sub       = 1'b0;
            bus.cin       = 1'b0;
            bus.out_ready = !(cyc >= 6 && cyc <= 8);
            @(negedge clk);
            acc_now = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                check($sformatf("b2b_sum%0d", got), 64'(bus.sum), 64'(2 * got));
                if (!bus.out_ready)
                    check($sformatf("b2b_stall_in_ready_c%0d", cyc), 64'(bus.in_ready), 64'd0);
                else
                    got++;
            end
            tick();
            if (acc_now) idx++;
            cyc++;
        end
        check("b2b_results", 64'(got), 64'd10);
        check("b2b_in_time", 64'(cyc < 100), 64'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();

        // Three beats in flight, then a one-cycle reset discards them.
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.a = 32'(100 + i);
            bus.b = 32'(i);
            @(negedge clk);
            check($sformatf("flush_accept%0d", i), 64'(bus.in_ready), 64'd1);
            tick();
        end
        reset    = 1'b1;
        bus.a    = 32'h55;
        bus.b    = 32'h1;
        tick();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            check($sformatf("flush_quiet%0d", n), 64'(bus.out_valid), 64'd0);
            tick();
        end
        run_beat("after_flush", 32'd1, 32'd1, 1'b0, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with random back-pressure.
        n_sent = 0; cyc = 0;
        while (n_sent < 300 && cyc < 5000) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.a         = rand_operand();
            bus.b         = rand_operand();
            bus.sub       = 1'($urandom_range(0, 1));
            bus.cin       = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) n_sent++;
            tick();
            cyc++;
        end
        check("random_sent", 64'(n_sent), 64'd300);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < STAGES + 4; n++) tick();
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/pipe_add.md
PIPE_ADD -- requirements
Module: pipe_add

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter STAGES, default 4, pipeline depth; WIDTH SHALL be an integer multiple of STAGES, STAGES >= 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 a, b  input  WIDTH  operands.
REQ-008 sub  input  1  0 = a+b+cin, 1 = a-b (a + ~b + 1; cin ignored).
REQ-009 cin  input  1  carry-in for add mode.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-013 cout  output  1  carry out of MSB (sub: 1 = no borrow).
REQ-014 ovf, zero  output  1 each  signed overflow; sum == 0.

Function
REQ-015 Datapath SHALL be split into STAGES chunks of CW = WIDTH/STAGES bits; stage k adds chunk k (LSB first) using the carry registered by stage k-1.
REQ-016 Upper operand chunks SHALL be skew-delayed so chunk k is added exactly k cycles after acceptance; lower result chunks SHALL be de-skewed so sum is presented whole.
REQ-017 Global advance = !out_valid || out_ready; all stage registers, including valid bits, SHALL load only when advance = 1.
REQ-018 in_ready SHALL equal advance; a beat is accepted when in_valid && in_ready.
REQ-019 Latency SHALL be exactly STAGES cycles from acceptance to out_valid with no stall; throughput one beat per cycle.
REQ-020 Empty stages (bubbles) SHALL collapse while out_valid = 0 even if out_ready = 0.
REQ-021 While out_valid && !out_ready, sum, cout, ovf, zero SHALL hold stable and no beat is accepted.
REQ-022 Results SHALL emerge in acceptance order; no beat lost or duplicated.
REQ-023 sub and cin SHALL be captured with the beat; changes after acceptance have no effect on it.
REQ-024 Carry wrap: all-ones + 1 SHALL give sum = 0, cout = 1.
REQ-025 ovf = carry into MSB XOR carry out of MSB; zero computed on final full sum.
REQ-026 STAGES = 1 SHALL give a single registered full-width adder, latency 1.

Reset
REQ-027 While reset = 1 at a clock edge, all valid bits SHALL clear; sum, cout, ovf, zero SHALL be 0; out_valid = 0.
REQ-028 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-029 Reset mid-operation SHALL discard all in-flight beats; none appear afterwards.
REQ-030 in_valid during reset SHALL be ignored.

Configuration
REQ-031 Macro PIPE_ADD_FLAGS_EN defined: ovf and zero generated per REQ-025.
REQ-032 Macro undefined: ovf and zero ports remain, tied to 0; no flag logic; sum/cout/timing unchanged.

Verification (WIDTH=32, STAGES=4)
REQ-033 Reset then a=5, b=7, sub=0, cin=0, out_ready=1 -> out_valid on 4th cycle after accept, sum=12, cout=0, zero=0.
REQ-034 a=32'hFFFF_FFFF, b=1, cin=0 -> sum=0, cout=1, zero=1, ovf=0; a=32'h7FFF_FFFF, b=1 -> sum=32'h8000_0000, ovf=1.
REQ-035 sub=1, a=3, b=5 -> sum=32'hFFFF_FFFE, cout=0; a=5, b=3 -> sum=2, cout=1.
REQ-036 10 back-to-back beats a=i, b=i, out_ready low cycles 6-8 -> in_ready low while output stalled, results 0,2,...,18 in order, none lost, sum stable while stalled.
REQ-037 Accept 3 beats, assert reset for 1 cycle at cycle 2 -> out_valid stays 0 for 6 cycles after reset; next beat a=1, b=1 -> sum=2 after 4 cycles.
REQ-038 Build without PIPE_ADD_FLAGS_EN, repeat REQ-034 -> sum/cout identical, ovf=0, zero=0.
